// File: rtl/inventory_fsm.sv
// Tracks which of N_ITEMS collectibles are held and scrolls the held items on a 7-segment digit.
// Latency: every output is registered and reflects an input edge one clk after it is sampled.
// No backpressure: sw and drop are edge-detected each cycle and never stalled.
module inventory_fsm #(
    parameter int N_ITEMS    = 4,
    parameter int SCROLL_DIV = 50_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_ITEMS-1:0] sw,
    input  logic               drop,
    output logic [N_ITEMS-1:0] v,
    output logic [3:0]         count,
    output logic               win,
    output logic [2:0]         cur_idx,
    output logic [6:0]         LED_out
);

    localparam int CW = $clog2(SCROLL_DIV);
    localparam logic [N_ITEMS-1:0] ALL_HELD = {N_ITEMS{1'b1}};
    localparam logic [N_ITEMS-1:0] ONE      = {{(N_ITEMS-1){1'b0}}, 1'b1};
    localparam logic [2:0]         TOP_IDX  = 3'(N_ITEMS - 1);

    localparam logic [6:0] SEG_EMPTY = 7'b0000001;
    localparam logic [6:0] SEG_WIN   = 7'b0001000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SHOW  = 2'd1,
        WIN   = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [N_ITEMS-1:0] sw_q;
    logic               drop_q;
    logic [N_ITEMS-1:0] pick;
    logic               drop_e;
    logic [N_ITEMS-1:0] cur_onehot;
    logic [N_ITEMS-1:0] dropmask;
    logic [N_ITEMS-1:0] v_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic [2:0]         idx_nx;
    logic [3:0]         count_nx;
    logic [6:0]         led_nx;

    // Next held index strictly above 'from', wrapping to the lowest set bit;
    // returns 'from' itself when it is the only held item.
    function automatic logic [2:0] next_set(input logic [N_ITEMS-1:0] vec,
                                            input logic [2:0]         from);
        logic [2:0] hi;
        logic [2:0] lo;
        logic       hi_f;
        logic       lo_f;
        hi   = 3'd0;
        lo   = 3'd0;
        hi_f = 1'b0;
        lo_f = 1'b0;
        for (int k = N_ITEMS - 1; k >= 0; k--) begin
            if (vec[k]) begin
                lo   = 3'(k);
                lo_f = 1'b1;
                if (3'(k) > from) begin
                    hi   = 3'(k);
                    hi_f = 1'b1;
                end
            end
        end
        if (hi_f)      return hi;
        else if (lo_f) return lo;
        else           return from;
    endfunction

    // Active-low abcdefg glyph for digit idx+1.
    function automatic logic [6:0] glyph(input logic [2:0] idx);
        case (idx)
            3'd0:    return 7'b1001111;
            3'd1:    return 7'b0010010;
            3'd2:    return 7'b0000110;
            3'd3:    return 7'b1001100;
            3'd4:    return 7'b0100100;
            3'd5:    return 7'b0100000;
            3'd6:    return 7'b0001111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Edge detect, held-vector update and next-state / next-output decode.
    always_comb begin
        pick       = sw & ~sw_q;
        drop_e     = drop & ~drop_q;
        cur_onehot = ONE << cur_idx;
        dropmask   = (state == SHOW && drop_e) ? cur_onehot : '0;
        // Pickup is ORed in after the drop so a same-cycle pickup wins.
        v_nx       = (v & ~dropmask) | pick;

        state_nx = state;
        idx_nx   = cur_idx;
        cnt_nx   = cnt;

        if (state == WIN || v_nx == ALL_HELD) begin
            state_nx = WIN;
            v_nx     = ALL_HELD;
            idx_nx   = 3'd0;
            cnt_nx   = '0;
        end else if (v_nx == '0) begin
            state_nx = EMPTY;
            idx_nx   = 3'd0;
            cnt_nx   = '0;
        end else if (state == EMPTY) begin
            state_nx = SHOW;
            idx_nx   = next_set(v_nx, TOP_IDX);
            cnt_nx   = '0;
        end else if ((v_nx & cur_onehot) == '0) begin
            // Displayed item just dropped: jump to the next held one immediately.
            idx_nx = next_set(v_nx, cur_idx);
            cnt_nx = '0;
        end else if (cnt == CW'(SCROLL_DIV - 1)) begin
            idx_nx = next_set(v_nx, cur_idx);
            cnt_nx = '0;
        end else begin
            cnt_nx = cnt + 1'b1;
        end

        count_nx = 4'd0;
        for (int k = 0; k < N_ITEMS; k++) begin
            count_nx = count_nx + {3'd0, v_nx[k]};
        end

        case (state_nx)
            SHOW:    led_nx = glyph(idx_nx);
            WIN:     led_nx = SEG_WIN;
            default: led_nx = SEG_EMPTY;
        endcase
    end

    // State, held vector and all registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EMPTY;
            v       <= '0;
            sw_q    <= '0;
            drop_q  <= 1'b0;
            cnt     <= '0;
            cur_idx <= 3'd0;
            count   <= 4'd0;
            win     <= 1'b0;
            LED_out <= SEG_EMPTY;
        end else begin
            state   <= state_nx;
            v       <= v_nx;
            sw_q    <= sw;
            drop_q  <= drop;
            cnt     <= cnt_nx;
            cur_idx <= idx_nx;
            count   <= count_nx;
            win     <= (state_nx == WIN);
            LED_out <= led_nx;
        end
    end

endmodule
